// File: rtl/blink_pkg.sv
// blink_pkg: shared port addresses and register bit positions for the blink RTC.
package blink_pkg;
    typedef enum logic [7:0] {
        ADDR_B0 = 8'hB0,
        ADDR_B1 = 8'hB1,
        ADDR_B4 = 8'hB4,
        ADDR_B5 = 8'hB5,
        ADDR_D0 = 8'hD0,
        ADDR_D1 = 8'hD1,
        ADDR_D2 = 8'hD2,
        ADDR_D3 = 8'hD3,
        ADDR_D4 = 8'hD4
    } port_e;
    localparam int COM_RESTIM = 4;
    localparam int INT_GINT   = 0;
    localparam int INT_TIME   = 1;
    localparam int STA_TIME   = 1;
    localparam int T_TICK     = 0;
    localparam int T_SEC      = 1;
    localparam int T_MIN      = 2;
endpackage

// File: rtl/blink_prescaler.sv
// blink_prescaler: divides mck into a one-cycle tick every TICK_DIV cycles.
module blink_prescaler #(
    parameter int TICK_DIV = 49152
) (
    input  logic mck,
    input  logic rin_n,
    input  logic clr,
    output logic tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = !clr && cnt_q == W'(TICK_DIV - 1);
        cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/blink_rtc.sv
// blink_rtc: tick/second/minute counters with maskable timer interrupts
// on the blink I/O register bus.
module blink_rtc
    import blink_pkg::*;
#(
    parameter int TICK_DIV      = 49152,
    parameter int TICKS_PER_SEC = 200,
    parameter int SECS_PER_MIN  = 60,
    parameter int MIN_W         = 21
) (
    input  logic       mck,
    input  logic       rin_n,
    input  logic       iow,
    input  logic       ior,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       intb_n
);
    logic             tick, hold, wrap0, wrap1, rd, hit, unused;
    logic             restim_q, restim_d, intb_q, intb_d, rvalid_q, rvalid_d;
    logic [1:0]       int_q, int_d;
    logic [2:0]       tmk_q, tmk_d, tsta_q, tsta_d, ev;
    logic [7:0]       tim0_q, tim0_d, tim1_q, tim1_d, sh_tim1_q, sh_tim1_d;
    logic [7:0]       rdata_q, rdata_d, rd_val, sta;
    logic [MIN_W-1:0] timm_q, timm_d, sh_timm_q, sh_timm_d;
    logic [23:0]      timm_x;

    assign unused = ^{wdata[7:5], wdata[3]};

    // Held off on the RESTIM write edge too, so the first tick after release
    // lands a full TICK_DIV cycles later and a same-edge tick is discarded.
    blink_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
        .mck   (mck),
        .rin_n (rin_n),
        .clr   (hold),
        .tick  (tick)
    );

    always_comb begin
        restim_d  = (iow && addr == ADDR_B0) ? wdata[COM_RESTIM] : restim_q;
        hold      = restim_q | restim_d;
        int_d     = (iow && addr == ADDR_B1) ? wdata[1:0] : int_q;
        tmk_d     = (iow && addr == ADDR_B5) ? wdata[2:0] : tmk_q;
        wrap0     = tick && tim0_q == 8'(TICKS_PER_SEC - 1);
        wrap1     = wrap0 && tim1_q == 8'(SECS_PER_MIN - 1);
        ev        = '0;
        ev[T_TICK] = tick & !hold;
        ev[T_SEC]  = wrap0 & !hold;
        ev[T_MIN]  = wrap1 & !hold;
        tsta_d    = (tsta_q & ~((iow && addr == ADDR_B4) ? wdata[2:0] : 3'b0)) | ev;
        tim0_d    = (hold || wrap0) ? '0 : tick ? tim0_q + 8'd1 : tim0_q;
        tim1_d    = (hold || wrap1) ? '0 : wrap0 ? tim1_q + 8'd1 : tim1_q;
        timm_d    = hold ? '0 : wrap1 ? timm_q + 1'b1 : timm_q;
        rd        = ior && !iow;
        hit       = addr inside {ADDR_B1, ADDR_B5, ADDR_D0, ADDR_D1, ADDR_D2, ADDR_D3, ADDR_D4};
        sh_tim1_d = (rd && addr == ADDR_D0) ? tim1_q : sh_tim1_q;
        sh_timm_d = (rd && addr == ADDR_D0) ? timm_q : sh_timm_q;
        timm_x    = 24'(sh_timm_q);
        sta       = '0;
        sta[STA_TIME] = |(tsta_q & tmk_q);
        rd_val    = addr == ADDR_B1 ? sta :
                    addr == ADDR_B5 ? {5'b0, tsta_q} :
                    addr == ADDR_D0 ? tim0_q :
                    addr == ADDR_D1 ? sh_tim1_q :
                    addr == ADDR_D2 ? timm_x[7:0] :
                    addr == ADDR_D3 ? timm_x[15:8] : timm_x[23:16];
        rvalid_d  = rd && hit;
        rdata_d   = rvalid_d ? rd_val : rdata_q;
        intb_d    = !(int_q[INT_GINT] & int_q[INT_TIME] & |(tsta_q & tmk_q));
    end

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            restim_q  <= 1'b0;
            int_q     <= '0;
            tmk_q     <= '0;
            tsta_q    <= '0;
            tim0_q    <= '0;
            tim1_q    <= '0;
            timm_q    <= '0;
            sh_tim1_q <= '0;
            sh_timm_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            intb_q    <= 1'b1;
        end else begin
            restim_q  <= restim_d;
            int_q     <= int_d;
            tmk_q     <= tmk_d;
            tsta_q    <= tsta_d;
            tim0_q    <= tim0_d;
            tim1_q    <= tim1_d;
            timm_q    <= timm_d;
            sh_tim1_q <= sh_tim1_d;
            sh_timm_q <= sh_timm_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            intb_q    <= intb_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign intb_n = intb_q;
endmodule

// File: tb/tb_blink_rtc.sv
// tb_blink_rtc: directed and random register traffic checked against a
// tick-count model (live time derived arithmetically from elapsed cycles).
module tb_blink_rtc;
    localparam int DIV = 4, TPS = 3, SPM = 2, MW = 21;

    logic       mck = 1'b0, rin_n = 1'b0, iow = 1'b0, ior = 1'b0;
    logic [7:0] addr = '0, wdata = '0, rdata;
    logic       rvalid, intb_n;

    int passes = 0, checks = 0;

    int unsigned ce;
    logic        restim_m, exp_rvalid, exp_intb;
    logic [2:0]  tsta_m, tmk_m;
    logic [1:0]  int_m;
    logic [7:0]  exp_rdata, sh_tim1;
    logic [23:0] sh_timm;

    blink_rtc #(.TICK_DIV(DIV), .TICKS_PER_SEC(TPS), .SECS_PER_MIN(SPM), .MIN_W(MW)) dut (
        .mck(mck), .rin_n(rin_n), .iow(iow), .ior(ior), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .intb_n(intb_n)
    );

    always #5 mck = ~mck;

    function automatic logic [7:0] tim0_of(int unsigned n); return 8'(n % TPS); endfunction
    function automatic logic [7:0] tim1_of(int unsigned n); return 8'((n / TPS) % SPM); endfunction
    function automatic logic [23:0] timm_of(int unsigned n);
        return 24'((n / (TPS * SPM)) % (1 << MW));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic mreset();
        ce = 0; restim_m = 0; tsta_m = 0; tmk_m = 0; int_m = 0;
        sh_tim1 = 0; sh_timm = 0; exp_rdata = 0; exp_rvalid = 0; exp_intb = 1;
    endtask

    // Apply one bus cycle, advance the model across the edge, check at negedge.
    task automatic step(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        int unsigned n;
        logic [2:0]  ev, ack;
        logic        rs_new, readable;
        iow = w; ior = r; addr = a; wdata = d;
        @(posedge mck);
        n = ce / DIV;
        exp_intb = !(int_m[0] && int_m[1] && |(tsta_m & tmk_m));
        readable = a inside {8'hB1, 8'hB5, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
        exp_rvalid = r && !w && readable;
        if (exp_rvalid) begin
            case (a)
                8'hB1:   exp_rdata = {6'b0, |(tsta_m & tmk_m), 1'b0};
                8'hB5:   exp_rdata = {5'b0, tsta_m};
                8'hD0:   exp_rdata = tim0_of(n);
                8'hD1:   exp_rdata = sh_tim1;
                8'hD2:   exp_rdata = sh_timm[7:0];
                8'hD3:   exp_rdata = sh_timm[15:8];
                default: exp_rdata = sh_timm[23:16];
            endcase
            if (a == 8'hD0) begin
                sh_tim1 = tim1_of(n);
                sh_timm = timm_of(n);
            end
        end
        rs_new = (w && a == 8'hB0) ? d[4] : restim_m;
        ev = 0;
        if (restim_m || rs_new) ce = 0;
        else begin
            ce++;
            if (ce % DIV == 0) ev = {(ce / DIV) % (TPS * SPM) == 0, (ce / DIV) % TPS == 0, 1'b1};
        end
        ack = (w && a == 8'hB4) ? d[2:0] : 3'b0;
        tsta_m = (tsta_m & ~ack) | ev;
        restim_m = rs_new;
        if (w && a == 8'hB1) int_m = d[1:0];
        if (w && a == 8'hB5) tmk_m = d[2:0];
        @(negedge mck);
        iow = 0; ior = 0;
        chk("rvalid", rvalid, exp_rvalid);
        chk("rdata", rdata, exp_rdata);
        chk("intb_n", intb_n, exp_intb);
    endtask

    task automatic idle(); step(0, 0, 8'h00, 8'h00); endtask
    task automatic rd(input logic [7:0] a); step(0, 1, a, 8'h00); endtask
    task automatic wr(input logic [7:0] a, input logic [7:0] d); step(1, 0, a, d); endtask

    task automatic wait_tick_next(input string tag);
        int k = 0;
        while ((ce + 1) % DIV != 0 && k < 20) begin idle(); k++; end
        chk(tag, k < 20, 1);
    endtask

    logic [7:0] addrs [10] = '{8'hB0, 8'hB1, 8'hB4, 8'hB5, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'h00};

    initial begin
        int k;
        logic [7:0] a, d;
        mreset();
        repeat (3) @(negedge mck);
        chk("rst_intb", intb_n, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        rin_n = 1;

        // Reset values through the bus; the model covers the first tick too.
        rd(8'hB1); rd(8'hB5); rd(8'hD0); rd(8'hD1); rd(8'hD2); rd(8'hD3); rd(8'hD4);

        // Cascade: 24 counting cycles = 6 ticks = 2 s = 1 min.
        k = 0;
        while (ce < 24 && k < 40) begin idle(); k++; end
        chk("wait24", ce, 24);
        rd(8'hD0); chk("d0_at24", rdata, 0);
        rd(8'hD1); chk("d1_at24", rdata, 0);
        rd(8'hD2); chk("d2_at24", rdata, 1);
        rd(8'hB5); chk("tsta_at24", rdata, 7);

        // Interrupt on tick, then acknowledge.
        wr(8'hB4, 8'h07); wr(8'hB5, 8'h01); wr(8'hB1, 8'h03);
        wait_tick_next("wait_tick1");
        idle();
        idle(); chk("intb_low", intb_n, 0);
        wr(8'hB4, 8'h01);
        idle(); chk("intb_high", intb_n, 1);

        // Ack in the tick cycle: set wins.
        wait_tick_next("wait_tick2");
        wr(8'hB4, 8'h01);
        rd(8'hB5); chk("tack_race", rdata[0], 1);

        // Shadow coherence.
        k = 0;
        while (tim1_of(ce / DIV) != 1 && k < 50) begin idle(); k++; end
        chk("wait_tim1", k < 50, 1);
        rd(8'hD0);
        k = 0;
        while (tim1_of(ce / DIV) == 1 && k < 50) begin idle(); k++; end
        chk("wait_carry", k < 50, 1);
        rd(8'hD1); chk("shadow_d1", rdata, 1);

        // RESTIM hold and release.
        wr(8'hB0, 8'h10); wr(8'hB4, 8'h07);
        repeat (100) idle();
        rd(8'hD0); chk("hold_d0", rdata, 0);
        rd(8'hD1); chk("hold_d1", rdata, 0);
        rd(8'hD2); chk("hold_d2", rdata, 0);
        rd(8'hB5); chk("hold_tsta", rdata, 0);
        wr(8'hB0, 8'h00);
        repeat (DIV - 1) idle();
        rd(8'hB5); chk("pre_first_tick", rdata, 0);
        rd(8'hB5); chk("first_tick", rdata[0], 1);

        // Random traffic, including simultaneous iow/ior and stray addresses.
        for (int i = 0; i < 400; i++) begin
            a = addrs[$urandom_range(0, 9)];
            if (a == 8'h00) a = 8'($urandom);
            d = 8'($urandom);
            if (a == 8'hB0) d = ($urandom_range(0, 3) == 0) ? 8'h10 : 8'h00;
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), a, d);
        end

        // Async reset while INT is asserted.
        wr(8'hB0, 8'h00); wr(8'hB5, 8'h07); wr(8'hB1, 8'h03);
        k = 0;
        while (exp_intb && k < 20) begin idle(); k++; end
        idle();
        chk("intb_before_rst", intb_n, 0);
        #2 rin_n = 0;
        #1 chk("async_intb", intb_n, 1);
        chk("async_rvalid", rvalid, 0);
        chk("async_rdata", rdata, 0);
        @(negedge mck);
        rin_n = 1;
        mreset();
        rd(8'hB5); rd(8'hD0); rd(8'hB1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
